// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the radix-2 in-place FFT core.
// Per frame: clear the core, stream N real samples in, pulse start,
// wait for done, then register the N bins onto a valid/idx/last stream.
module fft_frame_ctrl #(
    parameter int width = 16,
    parameter int N_2   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    input  logic               continuous,
    input  logic               abort,
    input  logic               sample_valid,
    input  logic [width-1:0]   sample_in,
    output logic               sample_ready,
    output logic               fft_reset,
    output logic               fft_load,
    output logic               fft_start,
    output logic [width-1:0]   fft_rd,
    input  logic               fft_done,
    input  logic [2*width-1:0] fft_wd,
    output logic               out_valid,
    output logic [2*width-1:0] out_data,
    output logic [N_2-1:0]     out_idx,
    output logic               out_last,
    output logic               busy
);

    // Counter value of the final sample / final bin (N-1) at counter width.
    localparam logic [N_2:0] LAST = {1'b0, {N_2{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        START,
        RUN,
        DRAIN
    } state_t;

    state_t         state;
    state_t         next;
    logic [N_2:0]   ld_cnt;
    logic [N_2:0]   bin_cnt;
    logic           abort_clr;
    logic           capture;

    // Counters saturate at N (MSB set), so bin_cnt < N is just "MSB clear".
    assign capture      = ((state == RUN) || (state == DRAIN)) && fft_done && !bin_cnt[N_2];

    assign sample_ready = (state == LOAD);
    assign fft_load     = sample_ready & sample_valid;
    assign fft_rd       = sample_in;
    assign fft_start    = (state == START);
    assign busy         = (state != IDLE);
    // abort_clr stretches an abort into one core-clear cycle so a partial
    // load never survives into the next frame.
    assign fft_reset    = reset | (state == CLR) | abort_clr;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    // Next-state logic; abort overrides everything, including go.
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (go) next = CLR;
            CLR:     next = LOAD;
            LOAD:    if (fft_load && (ld_cnt == LAST)) next = START;
            START:   next = RUN;
            RUN:     if (fft_done) next = DRAIN;
            DRAIN:   if (capture && (bin_cnt == LAST)) next = continuous ? CLR : IDLE;
            default: next = IDLE;
        endcase
        if (abort) next = IDLE;
    end

    // Sample/bin counters and the registered abort-clear flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_cnt    <= '0;
            bin_cnt   <= '0;
            abort_clr <= 1'b0;
        end else begin
            abort_clr <= abort;
            if (abort || (state == CLR)) begin
                ld_cnt  <= '0;
                bin_cnt <= '0;
            end else begin
                if (fft_load) ld_cnt  <= ld_cnt + 1'b1;
                if (capture)  bin_cnt <= bin_cnt + 1'b1;
            end
        end
    end

    // Output stage: register one bin per capture cycle; data/idx hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else if (capture && !abort) begin
            out_valid <= 1'b1;
            out_data  <= fft_wd;
            out_idx   <= bin_cnt[N_2-1:0];
            out_last  <= (bin_cnt == LAST);
        end else begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: behavioural FFT core stand-in, sample source,
// frame-level scoreboard and a table of whole-frame scenarios.
module tb_fft_frame_ctrl;
    localparam int W  = 16;
    localparam int N2 = 5;
    localparam int N  = 1 << N2;
    localparam int BUDGET = 5000;

    logic           clk = 0, reset = 0, go = 0, continuous = 0, abort = 0;
    logic           sample_valid = 0;
    logic [W-1:0]   sample_in = '0;
    logic           sample_ready, fft_reset, fft_load, fft_start;
    logic [W-1:0]   fft_rd;
    logic           fft_done;
    logic [2*W-1:0] fft_wd;
    logic           out_valid, out_last, busy;
    logic [2*W-1:0] out_data;
    logic [N2-1:0]  out_idx;

    fft_frame_ctrl #(.width(W), .N_2(N2)) dut (
        .clk(clk), .reset(reset), .go(go), .continuous(continuous), .abort(abort),
        .sample_valid(sample_valid), .sample_in(sample_in), .sample_ready(sample_ready),
        .fft_reset(fft_reset), .fft_load(fft_load), .fft_start(fft_start), .fft_rd(fft_rd),
        .fft_done(fft_done), .fft_wd(fft_wd),
        .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- core stand-in ----------------
    // Stores loaded samples in order; done_dly cycles after start it raises
    // done and emits bin k = {sample[N-1-k], ~k}, one per cycle.
    logic [W-1:0] core_mem [N];
    int           core_ld, core_cnt, core_bin;
    int           done_dly = 10;
    logic         core_run;

    always @(posedge clk) begin
        if (fft_reset) begin
            core_ld  <= 0;
            core_cnt <= 0;
            core_bin <= 0;
            core_run <= 1'b0;
            fft_done <= 1'b0;
        end else begin
            if (fft_load && core_ld < N) begin
                core_mem[core_ld] <= fft_rd;
                core_ld <= core_ld + 1;
            end
            if (fft_start) begin
                core_run <= 1'b1;
                core_cnt <= done_dly;
            end else if (core_run && !fft_done) begin
                if (core_cnt <= 1) fft_done <= 1'b1;
                else core_cnt <= core_cnt - 1;
            end
            if (fft_done) core_bin <= core_bin + 1;
        end
    end

    assign fft_wd = (fft_done && core_bin < N) ? {core_mem[N-1-core_bin], ~W'(core_bin)} : 32'hDEAD_BEEF;

    // ---------------- reference model ----------------
    // A frame is the next N samples the source hands over; its output burst
    // is the core transform of those samples, bins 0..N-1 in order.
    typedef struct { logic [2*W-1:0] data; int idx; } exp_t;
    exp_t         exp_q[$];
    logic [W-1:0] src_q[$];
    int           src_mode = 0;   // 0 steady, 1 toggle every cycle, 2 random gaps
    bit           took = 0;

    task automatic push_frame();
        logic [W-1:0] s[N];
        exp_t e;
        for (int i = 0; i < N; i++) begin
            s[i] = W'($urandom);
            src_q.push_back(s[i]);
        end
        for (int k = 0; k < N; k++) begin
            e.data = {s[N-1-k], ~W'(k)};
            e.idx  = k;
            exp_q.push_back(e);
        end
    endtask

    // Sample source: presents the queue head, pops it after an accept.
    initial begin
        logic [W-1:0] tmp;
        bit phase = 0;
        bit v;
        forever begin
            @(posedge clk); #1;
            if (took && src_q.size() > 0) tmp = src_q.pop_front();
            phase = ~phase;
            case (src_mode)
                0:       v = 1'b1;
                1:       v = phase;
                default: v = ($urandom_range(2) != 0);
            endcase
            sample_valid = v && (src_q.size() > 0);
            sample_in    = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    // ---------------- monitor ----------------
    int cyc = 0, n_load = 0, n_start = 0, n_last = 0, n_rst = 0;
    int first_ld = 0, last_ld = 0, start_cyc = 0, run_len = 0;
    bit prev_valid = 0, prev_fr = 0, post_start = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            took = sample_valid && sample_ready;
            if (fft_load) begin
                if (n_load == 0) first_ld = cyc;
                last_ld = cyc;
                n_load++;
            end
            if (fft_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (fft_reset && !prev_fr) n_rst++;
            prev_fr = fft_reset;
            if (fft_reset) post_start = 0;
            else if (post_start) check("ready_after_start", sample_ready, 0);
            if (fft_start) post_start = 1;
            if (reset) begin
                run_len    = 0;
                prev_valid = 0;
            end else begin
                if (out_valid) begin
                    if (out_last) n_last++;
                    if (exp_q.size() == 0) check("unexpected_bin", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check($sformatf("bin%0d_data", e.idx), out_data, e.data);
                        check($sformatf("bin%0d_idx", e.idx), out_idx, e.idx);
                        check($sformatf("bin%0d_last", e.idx), out_last, e.idx == N-1);
                    end
                    run_len = out_last ? 0 : run_len + 1;
                end else if (prev_valid) check("burst_gap", run_len, 0);
                prev_valid = out_valid;
            end
        end
    end

    // ---------------- scenarios ----------------
    typedef struct {
        bit cont; int mode; int dly; int nfr;
        int exp_loads; int exp_starts; int exp_lasts; int exp_rst; int exp_span;
    } scn_t;

    task automatic run_scn(input scn_t s, input int id);
        int budget;
        @(posedge clk); #1;
        n_load = 0; n_start = 0; n_last = 0; n_rst = 0;
        src_mode = s.mode; done_dly = s.dly; continuous = s.cont;
        for (int f = 0; f < s.nfr; f++) push_frame();
        go = 1;
        @(posedge clk); #1;
        go = 0;
        budget = 0;
        while (n_start < s.nfr && budget < BUDGET) begin @(posedge clk); #1; budget++; end
        continuous = 0;
        while ((busy || exp_q.size() != 0) && budget < BUDGET) begin @(posedge clk); #1; budget++; end
        check($sformatf("scn%0d_in_time", id), budget < BUDGET, 1);
        check($sformatf("scn%0d_loads", id), n_load, s.exp_loads);
        check($sformatf("scn%0d_starts", id), n_start, s.exp_starts);
        check($sformatf("scn%0d_lasts", id), n_last, s.exp_lasts);
        check($sformatf("scn%0d_clears", id), n_rst, s.exp_rst);
        check($sformatf("scn%0d_start_after_load", id), start_cyc, last_ld + 1);
        if (s.exp_span != 0) check($sformatf("scn%0d_load_span", id), last_ld - first_ld + 1, s.exp_span);
        check($sformatf("scn%0d_idle", id), busy, 0);
    endtask

    initial begin
        scn_t tbl[5];
        scn_t r;
        int   budget;
        tbl[0] = '{0, 0, 200, 1, 32, 1, 1, 1, 32};  // single frame, steady samples
        tbl[1] = '{0, 1,  10, 1, 32, 1, 1, 1, 63};  // sample_valid toggling
        tbl[2] = '{1, 0,  20, 3, 96, 3, 3, 3,  0};  // continuous, three frames
        tbl[3] = '{0, 2,   1, 1, 32, 1, 1, 1,  0};  // random gaps, minimal done delay
        tbl[4] = '{1, 2,   7, 2, 64, 2, 2, 2,  0};  // continuous with random gaps

        // Async reset with no clock edge yet.
        #1 reset = 1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_fft_reset", fft_reset, 1);
        check("rst_ready", sample_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        @(negedge clk);
        check("post_rst_fft_reset", fft_reset, 0);
        check("post_rst_busy", busy, 0);

        for (int i = 0; i < 5; i++) run_scn(tbl[i], i);

        // Abort after 10 accepts.
        @(posedge clk); #1;
        n_load = 0; n_start = 0; n_rst = 0; src_mode = 0;
        for (int i = 0; i < 10; i++) src_q.push_back(W'($urandom));
        go = 1;
        @(posedge clk); #1;
        go = 0;
        budget = 0;
        while (n_load < 10 && budget < BUDGET) begin @(posedge clk); #1; budget++; end
        check("abort_loads", n_load, 10);
        @(posedge clk); #1;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_fft_reset", fft_reset, 1);
        @(negedge clk);
        check("abort_fft_reset_end", fft_reset, 0);
        check("abort_no_start", n_start, 0);
        check("abort_clears", n_rst, 2);
        run_scn('{0, 0, 30, 1, 32, 1, 1, 1, 32}, 5);

        // Async reset in the middle of the output burst.
        @(posedge clk); #1;
        src_mode = 0; done_dly = 5;
        push_frame();
        go = 1;
        @(posedge clk); #1;
        go = 0;
        budget = 0;
        while (budget < BUDGET) begin
            @(negedge clk);
            budget++;
            if (out_valid && out_idx == 12) break;
        end
        check("drain_reached_bin12", budget < BUDGET, 1);
        #2 reset = 1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_idx", out_idx, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_fft_reset", fft_reset, 1);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 0;
        @(negedge clk);
        check("after_rst_busy", busy, 0);
        check("after_rst_out_valid", out_valid, 0);

        // Randomised frames.
        for (int i = 0; i < 4; i++) begin
            r.cont = 1'($urandom_range(1));
            r.mode = $urandom_range(2);
            r.dly  = $urandom_range(40, 1);
            r.nfr  = r.cont ? $urandom_range(3, 1) : 1;
            r.exp_loads = N * r.nfr; r.exp_starts = r.nfr; r.exp_lasts = r.nfr;
            r.exp_rst = r.nfr; r.exp_span = (r.mode == 0 && r.nfr == 1) ? N : 0;
            run_scn(r, 10 + i);
        end

        check("src_drained", src_q.size(), 0);
        check("exp_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
